// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, letter codes and FSM state type for the text line scheduler
// Contents:
//   GLYPH_W_DEF, GLYPH_H_DEF, CHAR_PITCH_DEF : default glyph geometry
//   CODE_A..CODE_Z, CODE_BLANK               : character codes held in the string register file
//   state_t                                  : fetch sequencer states
//   code_is_blank()                          : codes above Z never touch the font ROM
package text_pkg;

    localparam int GLYPH_W_DEF    = 15;
    localparam int GLYPH_H_DEF    = 17;
    localparam int CHAR_PITCH_DEF = 18;

    localparam logic [4:0] CODE_A = 5'd0;
    localparam logic [4:0] CODE_B = 5'd1;
    localparam logic [4:0] CODE_C = 5'd2;
    localparam logic [4:0] CODE_D = 5'd3;
    localparam logic [4:0] CODE_E = 5'd4;
    localparam logic [4:0] CODE_F = 5'd5;
    localparam logic [4:0] CODE_G = 5'd6;
    localparam logic [4:0] CODE_H = 5'd7;
    localparam logic [4:0] CODE_I = 5'd8;
    localparam logic [4:0] CODE_J = 5'd9;
    localparam logic [4:0] CODE_K = 5'd10;
    localparam logic [4:0] CODE_L = 5'd11;
    localparam logic [4:0] CODE_M = 5'd12;
    localparam logic [4:0] CODE_N = 5'd13;
    localparam logic [4:0] CODE_O = 5'd14;
    localparam logic [4:0] CODE_P = 5'd15;
    localparam logic [4:0] CODE_Q = 5'd16;
    localparam logic [4:0] CODE_R = 5'd17;
    localparam logic [4:0] CODE_S = 5'd18;
    localparam logic [4:0] CODE_T = 5'd19;
    localparam logic [4:0] CODE_U = 5'd20;
    localparam logic [4:0] CODE_V = 5'd21;
    localparam logic [4:0] CODE_W = 5'd22;
    localparam logic [4:0] CODE_X = 5'd23;
    localparam logic [4:0] CODE_Y = 5'd24;
    localparam logic [4:0] CODE_Z = 5'd25;
    localparam logic [4:0] CODE_BLANK = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    function automatic logic code_is_blank(input logic [4:0] code);
        return code > CODE_Z;
    endfunction

endpackage

// File: rtl/glyph_row_buffer.sv
// rtl/glyph_row_buffer.sv - one fetched glyph row per character slot for the current scanline
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (rows clear to 0)
//   wr_en, wr_idx, wr_data : capture port, indexed by fetch slot
//   rd_idx, rd_data        : combinational read by render character index (0 beyond MAX_CHARS)
module glyph_row_buffer #(
    parameter int MAX_CHARS = 24,
    parameter int GLYPH_W   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [4:0]         wr_idx,
    input  logic [GLYPH_W-1:0] wr_data,
    input  logic [4:0]         rd_idx,
    output logic [GLYPH_W-1:0] rd_data
);

    logic [GLYPH_W-1:0] rows [MAX_CHARS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                rows[i] <= '0;
            end
        end else if (wr_en && (wr_idx < 5'(MAX_CHARS))) begin
            rows[wr_idx] <= wr_data;
        end
    end

    // The render index free-runs outside the text box, so guard the read.
    assign rd_data = (rd_idx < 5'(MAX_CHARS)) ? rows[rd_idx] : '0;

endmodule

// File: rtl/text_line_scheduler.sv
// rtl/text_line_scheduler.sv - fetches one glyph row per character per scanline and serialises it to pixels
// Optional feature macro: TEXT_BG_EN (fill clear glyph bits inside the box with BG_COLOR)
// Ports:
//   clk, rst_n                 : pixel clock, asynchronous active-low reset
//   hcount, vcount             : raster position, hcount advances once per clock
//   x, y, str_len              : text box origin and string length, sampled at line start
//   char_wr_en/idx/code        : string register file write port
//   rom_addr, rom_data         : font ROM port, data one cycle after address
//   busy                       : fetch or drain in progress
//   text_on, pixel             : registered overlay output, one cycle after its hcount
module text_line_scheduler
    import text_pkg::*;
#(
    parameter int          MAX_CHARS  = 24,
    parameter int          GLYPH_W    = GLYPH_W_DEF,
    parameter int          GLYPH_H    = GLYPH_H_DEF,
    parameter int          CHAR_PITCH = CHAR_PITCH_DEF,
    parameter logic [23:0] FG_COLOR   = 24'hFF0000,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    input  logic [10:0]        x,
    input  logic [9:0]         y,
    input  logic [4:0]         str_len,
    input  logic               char_wr_en,
    input  logic [4:0]         char_wr_idx,
    input  logic [4:0]         char_wr_code,
    output logic [8:0]         rom_addr,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic               busy,
    output logic               text_on,
    output logic [23:0]        pixel
);

    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int COL_W = $clog2(CHAR_PITCH);

    state_t state, state_next;

    logic [4:0]       codes [MAX_CHARS];
    logic [4:0]       snap  [MAX_CHARS];
    logic             hz_q;
    logic             line_start;
    logic [4:0]       len_clamped;
    logic [10:0]      vdiff;
    logic             row_hit;
    logic             qualify;

    logic [ROW_W-1:0] line_row;
    logic [10:0]      line_x;
    logic [4:0]       line_len;
    logic [11:0]      line_end;
    logic             line_valid;
    logic [4:0]       issue_idx;
    logic [4:0]       issue_code;
    logic             issue_blank;
    logic             cap_pending;
    logic [4:0]       cap_slot;
    logic             cap_blank;

    logic [4:0]         r_idx, cur_idx;
    logic [COL_W-1:0]   r_col, cur_col;
    logic [GLYPH_W-1:0] rd_data;
    logic [GLYPH_W-1:0] shifted;
    logic               glyph_bit;
    logic               in_range;

    // Reset treats the previous hcount as zero so that releasing reset while
    // hcount sits at 0 does not fake a line start.
    assign line_start  = (hcount == 11'd0) && !hz_q;
    assign len_clamped = (str_len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : str_len;
    assign vdiff       = {1'b0, vcount} - {1'b0, y};
    assign row_hit     = (vcount >= y) && (vdiff < 11'(GLYPH_H));
    assign qualify     = line_start && row_hit && (len_clamped != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                codes[i] <= CODE_BLANK;
            end
        end else if (char_wr_en && (char_wr_idx < 5'(MAX_CHARS))) begin
            codes[char_wr_idx] <= char_wr_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (line_start) begin
            state_next = qualify ? ST_FETCH : ST_IDLE;
        end else begin
            case (state)
                ST_FETCH: if (issue_idx == line_len - 5'd1) state_next = ST_DRAIN;
                ST_DRAIN: state_next = ST_IDLE;
                default:  state_next = state;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        issue_code  = snap[issue_idx];
        issue_blank = code_is_blank(issue_code);
        rom_addr    = '0;
        if (state == ST_FETCH && !issue_blank) begin
            rom_addr = 9'(issue_code) * 9'(GLYPH_H) + 9'(line_row);
        end
    end

    // Fetch datapath. Each issued slot is remembered for one cycle so that
    // the ROM word arriving next cycle lands in the right buffer row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_q        <= 1'b1;
            line_row    <= '0;
            line_x      <= '0;
            line_len    <= '0;
            line_end    <= '0;
            line_valid  <= 1'b0;
            issue_idx   <= '0;
            cap_pending <= 1'b0;
            cap_slot    <= '0;
            cap_blank   <= 1'b0;
            for (int i = 0; i < MAX_CHARS; i++) begin
                snap[i] <= CODE_BLANK;
            end
        end else begin
            hz_q        <= (hcount == 11'd0);
            cap_pending <= 1'b0;
            if (line_start) begin
                line_valid <= 1'b0;
                issue_idx  <= '0;
                if (qualify) begin
                    line_row <= vdiff[ROW_W-1:0];
                    line_x   <= x;
                    line_len <= len_clamped;
                    line_end <= 12'(x) + 12'(len_clamped) * 12'(CHAR_PITCH);
                    snap     <= codes;
                end
            end else begin
                if (state == ST_FETCH) begin
                    cap_pending <= 1'b1;
                    cap_slot    <= issue_idx;
                    cap_blank   <= issue_blank;
                    issue_idx   <= issue_idx + 5'd1;
                end
                if (state == ST_DRAIN) begin
                    line_valid <= 1'b1;
                end
            end
        end
    end

    glyph_row_buffer #(
        .MAX_CHARS (MAX_CHARS),
        .GLYPH_W   (GLYPH_W)
    ) u_rows (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cap_pending),
        .wr_idx  (cap_slot),
        .wr_data (cap_blank ? '0 : rom_data),
        .rd_idx  (cur_idx),
        .rd_data (rd_data)
    );

    // Character index and column step with hcount and restart at the box's
    // left edge, so no division by CHAR_PITCH is needed.
    assign cur_idx  = (hcount == line_x) ? 5'd0 : r_idx;
    assign cur_col  = (hcount == line_x) ? '0 : r_col;
    assign in_range = line_valid && (hcount >= line_x) && ({1'b0, hcount} < line_end);
    // Shifting left puts column col at the MSB; columns past the glyph width
    // shift every bit out and read as 0 (the gap between characters).
    assign shifted   = rd_data << cur_col;
    assign glyph_bit = (cur_col < COL_W'(GLYPH_W)) && shifted[GLYPH_W-1];

`ifndef TEXT_BG_EN
    logic bg_unused;
    assign bg_unused = ^BG_COLOR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_col   <= '0;
            pixel   <= '0;
            text_on <= 1'b0;
        end else begin
            if (cur_col == COL_W'(CHAR_PITCH - 1)) begin
                r_col <= '0;
                r_idx <= cur_idx + 5'd1;
            end else begin
                r_col <= cur_col + COL_W'(1);
                r_idx <= cur_idx;
            end

            if (in_range && glyph_bit) begin
                pixel   <= FG_COLOR;
                text_on <= 1'b1;
            end
`ifdef TEXT_BG_EN
            else if (in_range) begin
                pixel   <= BG_COLOR;
                text_on <= 1'b1;
            end
`endif
            else begin
                pixel   <= '0;
                text_on <= 1'b0;
            end
        end
    end

endmodule
